// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package if_fetch_unit_pkg;

    localparam int IF_INSTR_W   = 16;
    localparam int IF_PC_W      = 8;
    localparam int IF_BUF_DEPTH = 2;

    localparam logic [IF_INSTR_W-1:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Two-entry prefetch buffer holding {instruction, pc+1}; flush beats push/pop.
module if_prefetch_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head_data,
    output logic [1:0]   count,
    output logic         full
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_pop;
    logic         do_push;

    assign full    = (count == 2'(DEPTH));
    assign do_pop  = pop && (count != 2'd0);
    // writing a full buffer is only safe when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one-outstanding memory fetch FSM, PC tracking and redirect,
// feeding a 2-entry prefetch buffer whose head drives the IF outputs.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int INSTR_W   = IF_INSTR_W,
    parameter int PC_W      = IF_PC_W,
    parameter int BUF_DEPTH = IF_BUF_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               id_stall,
    output logic [INSTR_W-1:0] IF_instruction,
    output logic [PC_W-1:0]    IF_PC_plus_1,
    output logic               if_valid
);

    fetch_state_e state;
    fetch_state_e state_nxt;

    logic [PC_W-1:0]         fetch_pc;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_flush;
    logic                    fifo_full;
    logic [1:0]              fifo_count;
    logic [INSTR_W+PC_W-1:0] head;
    logic                    accept;
    logic                    idle_room;
    logic                    can_refill;

    assign if_valid   = (fifo_count != 2'd0);
    assign fifo_flush = branch_taken;
    assign fifo_pop   = if_valid && !id_stall && !branch_taken;
    // fetch_pc already points past the outstanding address, so it is that entry's pc+1
    assign fifo_push  = (state == ST_WAIT) && imem_rvalid && !branch_taken;

    assign idle_room  = !fifo_full || fifo_pop;
    // back-to-back fetch only if the buffer still has room once the returning word lands
    assign can_refill = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && fifo_pop);

    assign accept    = imem_req && imem_gnt;
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (branch_taken || idle_room) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (!branch_taken && imem_gnt) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (branch_taken)    state_nxt = imem_rvalid ? ST_REQ : ST_DISCARD;
                else if (imem_rvalid) begin
                    if (accept)          state_nxt = ST_WAIT;
                    else if (can_refill) state_nxt = ST_REQ;
                    else                 state_nxt = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (imem_rvalid) state_nxt = ST_REQ;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        case (state)
            ST_REQ:  imem_req = !branch_taken;
            ST_WAIT: imem_req = imem_rvalid && !branch_taken && can_refill;
            default: imem_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             fetch_pc <= '0;
        else if (branch_taken) fetch_pc <= branch_target;
        else if (accept)       fetch_pc <= fetch_pc + PC_W'(1);
    end

    if_prefetch_fifo #(
        .W     (INSTR_W + PC_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({imem_rdata, fetch_pc}),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head_data (head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    assign IF_instruction = if_valid ? head[INSTR_W+PC_W-1:PC_W] : INSTR_W'(NOP);
    assign IF_PC_plus_1   = if_valid ? head[PC_W-1:0] : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory model returns addr*3 with selectable latency.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic        id_stall = 1'b0;
    logic [15:0] if_instr;
    logic [7:0]  if_pc1;
    logic        if_valid;

    logic        mdl_rvalid = 1'b0;
    logic [15:0] mdl_rdata = 16'h0;
    logic [7:0]  mdl_addr = 8'h0;
    logic        inj_rvalid = 1'b0;
    int          lat = 1;
    int          cd = 0;

    int          total = 0;
    int          bad = 0;
    int          ncons = 0;
    int          cnt0;
    logic [7:0]  exp_pc = 8'h01;
    logic        track_en = 1'b0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .id_stall       (id_stall),
        .IF_instruction (if_instr),
        .IF_PC_plus_1   (if_pc1),
        .if_valid       (if_valid)
    );

    // memory always accepts; data returns lat cycles after the grant cycle
    assign imem_gnt    = imem_req;
    assign imem_rvalid = mdl_rvalid | inj_rvalid;
    assign imem_rdata  = inj_rvalid ? 16'hDEAD : mdl_rdata;

    always @(posedge clk) begin
        mdl_rvalid <= 1'b0;
        if (cd == 1) begin
            mdl_rvalid <= 1'b1;
            mdl_rdata  <= {8'h00, mdl_addr} * 16'd3;
        end
        if (cd > 0) cd <= cd - 1;
        if (imem_req && imem_gnt) begin
            if (lat == 1) begin
                mdl_rvalid <= 1'b1;
                mdl_rdata  <= {8'h00, imem_addr} * 16'd3;
            end else begin
                mdl_addr <= imem_addr;
                cd       <= lat - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // in-order consumer: every popped head must be the next expected instruction
    task automatic track();
        logic [7:0] a;
        if (!reset)
            chk("no_full_push", 32'(dut.fifo_push && dut.fifo_count == 2'd2 && !dut.fifo_pop), 32'd0);
        if (track_en && !reset && if_valid && !id_stall && !branch_taken) begin
            a = exp_pc - 8'd1;
            chk("seq_pc", 32'(if_pc1), 32'(exp_pc));
            chk("seq_instr", 32'(if_instr), 32'({8'h00, a} * 16'd3));
            exp_pc = exp_pc + 8'd1;
            ncons++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        track();
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            step();
            mid();
        end
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n;
        n = 0;
        while (!if_valid && n < bound) begin
            step();
            mid();
            n++;
        end
        chk(tag, 32'(if_valid), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},   32'(imem_req),  32'd0);
        chk({tag, "_addr"},  32'(imem_addr), 32'd0);
        chk({tag, "_valid"}, 32'(if_valid),  32'd0);
        chk({tag, "_instr"}, 32'(if_instr),  32'd0);
        chk({tag, "_pc"},    32'(if_pc1),    32'd0);
    endtask

    initial begin
        step(); mid();
        chk_zero("rst");

        // cycle 0: release; zero-wait stream 0,3,6.. from cycle 3
        step(); reset = 1'b0; track_en = 1'b1; exp_pc = 8'h01; mid();
        chk("c0_req", 32'(imem_req), 32'd0);
        step(); mid();
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", 32'(imem_addr), 32'h00);
        step(); mid();
        chk("c2_valid", 32'(if_valid), 32'd0);
        chk("c2_addr", 32'(imem_addr), 32'h01);
        repeat (6) begin
            step(); mid();
            chk("stream_valid", 32'(if_valid), 32'd1);
        end
        chk("stream_cnt", 32'(ncons), 32'd6);

        // stall 4 cycles: buffer fills, outputs freeze at pc+1 = 7
        step(); id_stall = 1'b1; mid();
        chk("stall0_req", 32'(imem_req), 32'd0);
        repeat (3) begin
            step(); mid();
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_pc", 32'(if_pc1), 32'h07);
            chk("stall_instr", 32'(if_instr), 32'd18);
        end
        step(); id_stall = 1'b0; mid();
        cnt0 = ncons;
        cyc(8);
        chk("stall_resume", 32'(ncons - cnt0 >= 6), 32'd1);

        // redirect to 0xFE: pc+1 runs FF, 00, 01 and addresses wrap
        step(); branch_taken = 1'b1; branch_target = 8'hFE; exp_pc = 8'hFF; mid();
        step(); branch_taken = 1'b0; mid();
        chk("wrap_flush", 32'(if_valid), 32'd0);
        chk("wrap_req", 32'(imem_req), 32'd1);
        chk("wrap_addr_fe", 32'(imem_addr), 32'hFE);
        step(); mid();
        chk("wrap_addr_ff", 32'(imem_addr), 32'hFF);
        step(); mid();
        chk("wrap_pc_ff", 32'(if_pc1), 32'hFF);
        chk("wrap_addr_00", 32'(imem_addr), 32'h00);
        step(); mid();
        chk("wrap_pc_00", 32'(if_pc1), 32'h00);
        chk("wrap_instr_ff", 32'(if_instr), 32'h02FD);
        step(); mid();
        chk("wrap_pc_01", 32'(if_pc1), 32'h01);

        // branch together with stall and rvalid: flush wins
        step(); branch_taken = 1'b1; branch_target = 8'h20; id_stall = 1'b1; exp_pc = 8'h21; mid();
        step(); branch_taken = 1'b0; id_stall = 1'b0; mid();
        chk("bs_flush", 32'(if_valid), 32'd0);
        chk("bs_req", 32'(imem_req), 32'd1);
        chk("bs_addr", 32'(imem_addr), 32'h20);
        step(); mid();
        chk("bs_valid_lat", 32'(if_valid), 32'd0);
        step(); mid();
        chk("bs_valid", 32'(if_valid), 32'd1);
        chk("bs_pc", 32'(if_pc1), 32'h21);

        // 3-cycle memory: branch to 0x40 while waiting, stale word dropped
        step(); reset = 1'b1; mid();
        chk_zero("rst2");
        lat = 3;
        step(); reset = 1'b0; exp_pc = 8'h01; mid();
        step(); mid();
        chk("l3_req", 32'(imem_req), 32'd1);
        chk("l3_addr", 32'(imem_addr), 32'h00);
        step(); branch_taken = 1'b1; branch_target = 8'h40; exp_pc = 8'h41; mid();
        chk("l3_wait_req", 32'(imem_req), 32'd0);
        step(); branch_taken = 1'b0; mid();
        chk("disc_req0", 32'(imem_req), 32'd0);
        step(); mid();
        chk("disc_req1", 32'(imem_req), 32'd0);
        chk("disc_valid", 32'(if_valid), 32'd0);
        step(); mid();
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", 32'(imem_addr), 32'h40);
        chk("redir_valid", 32'(if_valid), 32'd0);
        wait_valid("redir_timeout", 10);
        chk("redir_pc", 32'(if_pc1), 32'h41);
        chk("redir_instr", 32'(if_instr), 32'h00C0);

        // reset in WAIT for 2 cycles, then a late rvalid with no request issued
        step(); reset = 1'b1; exp_pc = 8'h01; mid();
        chk_zero("rstw");
        step(); mid();
        chk_zero("rstw2");
        step(); reset = 1'b0; inj_rvalid = 1'b1; mid();
        chk("late_req", 32'(imem_req), 32'd0);
        chk("late_valid", 32'(if_valid), 32'd0);
        step(); inj_rvalid = 1'b0; mid();
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", 32'(imem_addr), 32'h00);
        chk("post_rst_valid", 32'(if_valid), 32'd0);
        wait_valid("post_rst_timeout", 10);
        chk("post_rst_pc", 32'(if_pc1), 32'h01);
        chk("post_rst_instr", 32'(if_instr), 32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter INSTR_W, default 16, instruction width in bits.
REQ-002 Parameter PC_W, default 8, PC and instruction-memory address width in bits.
REQ-003 Parameter BUF_DEPTH, default 2, prefetch buffer entries; fixed at 2 for this release.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 imem_req  output  1  fetch request, held high until the cycle after acceptance.
REQ-007 imem_addr  output  PC_W  fetch address, stable while imem_req is high.
REQ-008 imem_gnt  input  1  request accepted this cycle.
REQ-009 imem_rvalid  input  1  read data valid; at least 1 cycle after the grant.
REQ-010 imem_rdata  input  INSTR_W  instruction word.
REQ-011 branch_taken  input  1  redirect pulse from ID or EX.
REQ-012 branch_target  input  PC_W  redirect address.
REQ-013 id_stall  input  1  downstream hold; the buffer head is not consumed.
REQ-014 IF_instruction  output  INSTR_W  buffer head; 0 (NOP) when if_valid is low.
REQ-015 IF_PC_plus_1  output  PC_W  address of the head instruction + 1, mod 2^PC_W; 0 when if_valid is low.
REQ-016 if_valid  output  1  head entry valid.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and DISCARD.
- IDLE->REQ when free slots minus outstanding fetches is at least 1.
- REQ->WAIT on imem_gnt.
- WAIT->IDLE or WAIT->REQ on imem_rvalid.
- At most one fetch SHALL be outstanding.
REQ-018 On imem_gnt, fetch_pc SHALL increment by 1, wrapping 0xFF->0x00.
REQ-019 On imem_rvalid in WAIT, the unit SHALL push {imem_rdata, issuing address + 1} into the buffer.
REQ-020 The head SHALL pop on a cycle where if_valid=1 and id_stall=0 and branch_taken=0.
REQ-021 Push and pop in the same cycle with a full buffer SHALL be legal; the count SHALL remain 2.
REQ-022 A push SHALL never be issued to a full buffer; REQ-017 guarantees this, and the bench SHALL assert it.
REQ-023 On branch_taken:
- flush the buffer; if_valid SHALL be 0 next cycle;
- set fetch_pc = branch_target;
- in REQ, imem_req SHALL drop and reissue with the new address next cycle;
- in WAIT, go to DISCARD.
REQ-024 DISCARD SHALL drop the pending imem_rvalid data, then go to REQ.
REQ-025 branch_taken SHALL have priority over pop, push and id_stall in the same cycle.
REQ-026 Latency SHALL be 2 cycles plus memory latency from fetch_pc update to if_valid, with zero-wait memory: grant in the request cycle, rvalid the next cycle.
REQ-027 With id_stall=0 and a zero-wait memory, the unit SHALL sustain one instruction per cycle.
REQ-028 Outputs SHALL come directly from buffer registers, with no combinational path from imem_rdata.

Reset
REQ-029 On assertion of reset, asynchronously:
- fetch_pc=0, FSM=IDLE, buffer empty;
- imem_req=0, imem_addr=0;
- if_valid=0, IF_instruction=0, IF_PC_plus_1=0.
REQ-030 Reset asserted in WAIT SHALL discard the outstanding response; an imem_rvalid arriving after deassertion with no request issued SHALL be ignored.
REQ-031 The first request SHALL go out in the first cycle after reset deassertion, with address 0x00.

Structure
REQ-032 A shared package SHALL hold INSTR_W, PC_W, the FSM state encoding and the NOP constant (16'h0000).
REQ-033 The buffer SHALL be a sub-module if_prefetch_fifo (2-entry, push/pop/flush/count); the FSM and PC logic SHALL stay in if_fetch_unit.

Verification
REQ-034 Zero-wait memory returning addr*3, id_stall=0 -> from cycle 3, IF_instruction = 0,3,6,... with IF_PC_plus_1 = 1,2,3,..., one per cycle.
REQ-035 id_stall held for 4 cycles with the buffer full -> outputs frozen, imem_req=0, no lost or duplicated instruction after release.
REQ-036 branch_taken, branch_target=0x40, raised in WAIT with 3-cycle memory latency -> stale data dropped, next valid output has IF_PC_plus_1=0x41.
REQ-037 Run from PC 0xFE -> IF_PC_plus_1 sequence 0xFF, 0x00, 0x01; addresses wrap to 0x00.
REQ-038 Reset asserted mid-WAIT, released 2 cycles later, late rvalid injected -> ignored, first request at address 0x00, all outputs 0 during reset.
REQ-039 branch_taken coincident with id_stall and rvalid -> flush wins, if_valid=0 next cycle, fetch resumes at branch_target.
